// File: rtl/tug_war_lights_score.sv
// rtl/tug_war_lights_score.sv - two-player tug-of-war light bar with per-player scores
module tug_war_lights_score #(
    parameter int MAX_SCORE = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    output logic [8:0] LEDR,
    output logic [6:0] D1,
    output logic [6:0] D2
);

    localparam logic [8:0] CENTRE    = 9'b000010000;
    localparam logic [2:0] MAX_SC    = 3'(MAX_SCORE);

    logic [8:0] bar_q, bar_d;
    logic [2:0] score_l_q, score_l_d;
    logic [2:0] score_r_q, score_r_d;
    logic       over_q, over_d;

    logic       pl, pr, mv_l, mv_r;
    logic [2:0] inc_l, inc_r;

    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            3'd7:    s = 7'b1111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // A pull on the player's own end LED scores instead of moving.
    always_comb begin
        pl    = bar_q[8] & L & ~R & ~over_q;
        pr    = bar_q[0] & R & ~L & ~over_q;
        mv_l  = L & ~R & ~over_q & ~pl;
        mv_r  = R & ~L & ~over_q & ~pr;
        inc_l = score_l_q + 3'd1;
        inc_r = score_r_q + 3'd1;
    end

    always_comb begin
        bar_d     = bar_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        over_d    = over_q;
        if (pl) begin
            bar_d = CENTRE;
            if (score_l_q < MAX_SC) begin
                score_l_d = inc_l;
                if (inc_l == MAX_SC) begin
                    over_d = 1'b1;
                    bar_d  = '0;
                end
            end
        end else if (pr) begin
            bar_d = CENTRE;
            if (score_r_q < MAX_SC) begin
                score_r_d = inc_r;
                if (inc_r == MAX_SC) begin
                    over_d = 1'b1;
                    bar_d  = '0;
                end
            end
        end else if (mv_l) begin
            bar_d = {bar_q[7:0], 1'b0};
        end else if (mv_r) begin
            bar_d = {1'b0, bar_q[8:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bar_q     <= CENTRE;
            score_l_q <= '0;
            score_r_q <= '0;
            over_q    <= 1'b0;
        end else begin
            bar_q     <= bar_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        LEDR = bar_q;
        D1   = seg7(score_r_q);
        D2   = seg7(score_l_q);
    end

endmodule

// File: tb/tb_tug_war_lights_score.sv
// tb/tb_tug_war_lights_score.sv - scoreboard bench with a position/score reference model
module tb_tug_war_lights_score;

    localparam int MAX = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       L = 1'b0;
    logic       R = 1'b0;
    logic [8:0] LEDR;
    logic [6:0] D1, D2;

    tug_war_lights_score #(.MAX_SCORE(MAX)) dut (
        .clk  (clk),
        .reset(reset),
        .L    (L),
        .R    (R),
        .LEDR (LEDR),
        .D1   (D1),
        .D2   (D2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] ledr;
        logic [6:0] d1;
        logic [6:0] d2;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;
    logic [6:0] seg_tab [0:7];

    // Reference model: light position as an index, scores as integers.
    int m_pos = 4, m_sl = 0, m_sr = 0;
    bit m_over = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int st);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, st, act, req);
        end
    endtask

    task automatic step(input logic rl, input logic l, input logic r);
        exp_t e;
        @(posedge clk);
        #2;
        reset = rl;
        L     = l;
        R     = r;
        step_no++;
        if (rl) begin
            m_pos = 4; m_sl = 0; m_sr = 0; m_over = 0;
        end else if (!m_over && l && !r) begin
            if (m_pos == 8) begin
                m_sl++; m_pos = 4;
                if (m_sl == MAX) m_over = 1;
            end else m_pos++;
        end else if (!m_over && r && !l) begin
            if (m_pos == 0) begin
                m_sr++; m_pos = 4;
                if (m_sr == MAX) m_over = 1;
            end else m_pos--;
        end
        e.ledr = m_over ? 9'd0 : 9'(1 << m_pos);
        e.d1   = seg_tab[m_sr];
        e.d2   = seg_tab[m_sl];
        e.step = step_no;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ledr", 32'(LEDR), 32'(e.ledr), e.step);
                check("d1",   32'(D1),   32'(e.d1),   e.step);
                check("d2",   32'(D2),   32'(e.d2),   e.step);
            end
        end
    end

    initial begin
        int mode;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;

        repeat (2) step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        repeat (5) step(0, 1, 0);
        repeat (3) step(0, 1, 1);
        repeat (5) step(0, 0, 1);
        // Drive the left player to game over, then poke the frozen game.
        repeat (7 * 5) step(0, 1, 0);
        repeat (4) step(0, 1, 0);
        repeat (4) step(0, 0, 1);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);

        for (int c = 0; c < 150; c++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 20; k++) begin
                logic rl, l, r;
                rl = ($urandom_range(0, 299) == 0);
                case (mode)
                    0:       begin l = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 1); end
                    1:       begin l = ($urandom_range(0, 9) < 1); r = ($urandom_range(0, 9) < 8); end
                    default: begin l = 1'($urandom); r = 1'($urandom); end
                endcase
                step(rl, l, r);
            end
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
